// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM control unit: states, instruction
// classes, condition codes, datapath select codes and small decode helpers.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_LINK   = 3'd5,
      ST_BRANCH = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_DPI = 3'd0,
      CLS_DPR = 3'd1,
      CLS_DPM = 3'd2,
      CLS_BR  = 3'd3,
      CLS_UND = 3'd4
   } class_e;

   // ARM condition codes
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam logic [3:0] ALU_OP_ADD = 4'b0100;

   localparam logic [1:0] PC_S_INC    = 2'b00;
   localparam logic [1:0] PC_S_BRANCH = 2'b01;

   localparam logic [1:0] RS_IMM_RS   = 2'b00;
   localparam logic [1:0] RS_IMM_SH5  = 2'b01;
   localparam logic [1:0] RS_IMM_ROT  = 2'b10;

   // Classify the instruction word; anything unrecognised runs as a NOP.
   function automatic class_e decode_class(input logic [31:0] instr);
      class_e cls;
      if (instr[27:25] == 3'b101) begin
         cls = CLS_BR;
      end else if (instr[27:26] != 2'b00) begin
         cls = CLS_UND;
      end else if (instr[25] == 1'b1) begin
         cls = CLS_DPM;
      end else if (instr[4] == 1'b0) begin
         cls = CLS_DPI;
      end else if (instr[7] == 1'b0) begin
         cls = CLS_DPR;
      end else begin
         cls = CLS_UND;
      end
      return cls;
   endfunction

   // TST/TEQ/CMP/CMN only set flags and never write a register.
   function automatic logic is_compare(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_cond_check.sv
// Combinational ARM condition evaluator; the never code (1111) is false.
module cond_check
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n_s, z_s, c_s, v_s;
   assign {n_s, z_s, c_s, v_s} = nzcv_i;

   // Map each condition code onto its flag expression.
   always_comb begin
      pass_o = 1'b0;
      case (cond_i)
         COND_EQ: pass_o = z_s;
         COND_NE: pass_o = ~z_s;
         COND_CS: pass_o = c_s;
         COND_CC: pass_o = ~c_s;
         COND_MI: pass_o = n_s;
         COND_PL: pass_o = ~n_s;
         COND_VS: pass_o = v_s;
         COND_VC: pass_o = ~v_s;
         COND_HI: pass_o = c_s & ~z_s;
         COND_LS: pass_o = ~c_s | z_s;
         COND_GE: pass_o = (n_s == v_s);
         COND_LT: pass_o = (n_s != v_s);
         COND_GT: pass_o = ~z_s & (n_s == v_s);
         COND_LE: pass_o = z_s | (n_s != v_s);
         COND_AL: pass_o = 1'b1;
         COND_NV: pass_o = 1'b0;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control FSM for the branch-capable ARM datapath. Outputs are a
// Moore decode of the state register and the (stable) instruction register.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      I,
   input  logic [3:0]       NZCV,
   output logic             Write_PC,
   output logic             Write_IR,
   output logic             Write_Reg,
   output logic             LA,
   output logic             LB,
   output logic             LC,
   output logic             LF,
   output logic             S,
   output logic             rm_imm_s,
   output logic [1:0]       rs_imm_s,
   output logic [3:0]       ALU_OP,
   output logic [2:0]       SHIFT_OP,
   output logic [1:0]       PC_s,
   output logic             rd_s,
   output logic             ALU_A_s,
   output logic             ALU_B_s,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] inst_cnt
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   class_e           cls_s;
   logic             pass_s;
   logic             link_s;
   logic             unused_s;

   assign cls_s    = decode_class(I);
   assign link_s   = I[24];
   assign unused_s = ^{I[19:8], I[3:0]};

   cond_check u_cond (
      .cond_i (I[31:28]),
      .nzcv_i (NZCV),
      .pass_o (pass_s)
   );

   // State sequencing and retired-instruction counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_INIT:   state_q <= ST_FETCH;
            ST_FETCH:  state_q <= ST_DECODE;
            ST_DECODE: begin
               if (!pass_s || (cls_s == CLS_UND)) begin
                  state_q <= ST_FETCH;
               end else begin
                  cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (cls_s == CLS_BR) begin
                     state_q <= link_s ? ST_LINK : ST_BRANCH;
                  end else begin
                     state_q <= ST_EXEC;
                  end
               end
            end
            ST_EXEC:   state_q <= is_compare(I[24:21]) ? ST_FETCH : ST_WB;
            ST_WB:     state_q <= ST_FETCH;
            ST_LINK:   state_q <= ST_BRANCH;
            ST_BRANCH: state_q <= ST_FETCH;
            default:   state_q <= ST_INIT;
         endcase
      end
   end

   // Per-state control strobes and selects; anything not driven stays 0.
   always_comb begin
      Write_PC  = 1'b0;
      Write_IR  = 1'b0;
      Write_Reg = 1'b0;
      LA        = 1'b0;
      LB        = 1'b0;
      LC        = 1'b0;
      LF        = 1'b0;
      S         = 1'b0;
      rm_imm_s  = 1'b0;
      rs_imm_s  = RS_IMM_RS;
      ALU_OP    = 4'b0000;
      SHIFT_OP  = 3'b000;
      PC_s      = PC_S_INC;
      rd_s      = 1'b0;
      ALU_A_s   = 1'b0;
      ALU_B_s   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            Write_IR = 1'b1;
            Write_PC = 1'b1;
            PC_s     = PC_S_INC;
         end
         ST_DECODE: begin
            LA = 1'b1;
            LB = 1'b1;
            LC = 1'b1;
         end
         ST_EXEC: begin
            LF     = 1'b1;
            ALU_OP = I[24:21];
            S      = I[20] | is_compare(I[24:21]);
            case (cls_s)
               CLS_DPI: begin
                  rs_imm_s = RS_IMM_SH5;
                  SHIFT_OP = {I[6:5], 1'b0};
               end
               CLS_DPR: begin
                  rs_imm_s = RS_IMM_RS;
                  SHIFT_OP = {I[6:5], 1'b1};
               end
               CLS_DPM: begin
                  rm_imm_s = 1'b1;
                  rs_imm_s = RS_IMM_ROT;
                  SHIFT_OP = 3'b111;
               end
               default: begin
                  rs_imm_s = RS_IMM_RS;
                  SHIFT_OP = 3'b000;
               end
            endcase
         end
         ST_WB: begin
            Write_Reg = 1'b1;
            rd_s      = 1'b0;
         end
         ST_LINK: begin
            LF      = 1'b1;
            ALU_A_s = 1'b1;
            ALU_B_s = 1'b1;
            ALU_OP  = ALU_OP_ADD;
            S       = 1'b0;
         end
         ST_BRANCH: begin
            Write_PC = 1'b1;
            PC_s     = PC_S_BRANCH;
            if (link_s) begin
               Write_Reg = 1'b1;
               rd_s      = 1'b1;
            end else begin
               Write_Reg = 1'b0;
               rd_s      = 1'b0;
            end
         end
         default: begin
            Write_PC = 1'b0;
         end
      endcase
   end

   assign state    = state_q;
   assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: directed test-plan instructions followed by random
// instructions, each compared cycle by cycle with an instruction-level model.
module tb_cpu_ctrl_fsm;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       wpc, wir, wreg, la, lb, lc, lf, s, rmi;
      logic [1:0] rsi;
      logic [3:0] aop;
      logic [2:0] sop;
      logic [1:0] pcs;
      logic       rds, aas, abs;
      logic [2:0] st;
   } ctl_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      I = 32'h0;
   logic [3:0]       NZCV = 4'h0;
   logic             Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s;
   logic [1:0]       rs_imm_s, PC_s;
   logic [3:0]       ALU_OP;
   logic [2:0]       SHIFT_OP, state;
   logic             rd_s, ALU_A_s, ALU_B_s;
   logic [CNT_W-1:0] inst_cnt;

   ctl_t obs;
   assign obs = {Write_PC, Write_IR, Write_Reg, LA, LB, LC, LF, S, rm_imm_s,
                 rs_imm_s, ALU_OP, SHIFT_OP, PC_s, rd_s, ALU_A_s, ALU_B_s, state};

   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_cnt = 0;
   ctl_t exp_q[$];

   cpu_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .I(I), .NZCV(NZCV),
      .Write_PC(Write_PC), .Write_IR(Write_IR), .Write_Reg(Write_Reg),
      .LA(LA), .LB(LB), .LC(LC), .LF(LF), .S(S),
      .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .ALU_OP(ALU_OP),
      .SHIFT_OP(SHIFT_OP), .PC_s(PC_s), .rd_s(rd_s), .ALU_A_s(ALU_A_s),
      .ALU_B_s(ALU_B_s), .state(state), .inst_cnt(inst_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // ARM condition semantics: odd codes negate the even code's test.
   function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      if (c == 4'hE) return 1'b1;
      return base ^ c[0];
   endfunction

   function automatic ctl_t blank(input logic [2:0] st);
      ctl_t r = '0;
      r.st = st;
      return r;
   endfunction

   // Build the expected per-cycle control trace of one instruction.
   function automatic void build(input logic [31:0] ins, input logic [3:0] f);
      ctl_t r;
      int   kind; // 0 DPI, 1 DPR, 2 DPM, 3 BR, 4 undefined
      bit   ok, lnk, cmp;
      if (ins[27:25] == 3'b101) kind = 3;
      else if (ins[27:26] != 2'b00) kind = 4;
      else if (ins[25]) kind = 2;
      else if (!ins[4]) kind = 0;
      else if (!ins[7]) kind = 1;
      else kind = 4;
      ok  = cond_ok(ins[31:28], f) && (kind != 4);
      lnk = ins[24];
      cmp = (ins[24:21] >= 4'd8) && (ins[24:21] <= 4'd11);
      exp_q.delete();
      r = blank(3'd1); r.wir = 1'b1; r.wpc = 1'b1; exp_q.push_back(r);
      r = blank(3'd2); r.la = 1'b1; r.lb = 1'b1; r.lc = 1'b1; exp_q.push_back(r);
      if (!ok) return;
      exp_cnt++;
      if (kind == 3) begin
         if (lnk) begin
            r = blank(3'd5); r.lf = 1'b1; r.aas = 1'b1; r.abs = 1'b1; r.aop = 4'd4;
            exp_q.push_back(r);
         end
         r = blank(3'd6); r.wpc = 1'b1; r.pcs = 2'd1; r.wreg = lnk; r.rds = lnk;
         exp_q.push_back(r);
      end else begin
         r = blank(3'd3); r.lf = 1'b1; r.aop = ins[24:21]; r.s = ins[20] | cmp;
         if (kind == 0) begin r.rsi = 2'd1; r.sop = {ins[6:5], 1'b0}; end
         else if (kind == 1) begin r.rsi = 2'd0; r.sop = {ins[6:5], 1'b1}; end
         else begin r.rmi = 1'b1; r.rsi = 2'd2; r.sop = 3'b111; end
         exp_q.push_back(r);
         if (!cmp) begin
            r = blank(3'd4); r.wreg = 1'b1; exp_q.push_back(r);
         end
      end
   endfunction

   // Run one instruction starting in FETCH; ends back in FETCH.
   task automatic run_instr(input logic [31:0] ins, input logic [3:0] f, input string tag);
      I = ins;
      NZCV = f;
      build(ins, f);
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("%s/cyc%0d", tag, k), 32'(obs), 32'(exp_q[k]));
         tick();
      end
      check($sformatf("%s/cnt", tag), 32'(inst_cnt), 32'(exp_cnt % (1 << CNT_W)));
   endtask

   initial begin
      logic [31:0] ins;
      int          sel;
      // reset held for two cycles
      rst = 1'b1;
      tick();
      check("rst_hold1", 32'(obs), 32'(blank(3'd0)));
      tick();
      check("rst_hold2", 32'(obs), 32'(blank(3'd0)));
      check("rst_cnt", 32'(inst_cnt), 32'd0);
      rst = 1'b0;
      tick();
      check("rst_release_state", 32'(state), 32'd1);
      check("rst_release_cnt", 32'(inst_cnt), 32'd0);

      // directed test-plan instructions
      run_instr(32'hE0821003, 4'h0, "add");
      run_instr(32'hE3510005, 4'h0, "cmp");
      run_instr(32'h0A000003, 4'h0, "beq_nt");
      run_instr(32'h0A000003, 4'h4, "beq_t");
      run_instr(32'hEB000010, 4'h0, "bl");
      run_instr(32'hE7F000F0, 4'h0, "und");
      run_instr(32'hF0821003, 4'hF, "add_nv");

      // reset during EXEC of ADD abandons it with no register write
      I = 32'hE0821003;
      NZCV = 4'h0;
      build(I, NZCV);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("add_rst/cyc%0d", k), 32'(obs), 32'(exp_q[k]));
         if (k < 2) tick();
      end
      rst = 1'b1;
      tick();
      check("add_rst/init", 32'(obs), 32'(blank(3'd0)));
      check("add_rst/wreg", 32'(Write_Reg), 32'd0);
      check("add_rst/cnt", 32'(inst_cnt), 32'd0);
      exp_cnt = 0;
      rst = 1'b0;
      tick();
      check("add_rst/fetch", 32'(state), 32'd1);

      // random instructions biased toward each class; counter wraps at 2^CNT_W
      for (int n = 0; n < 300; n++) begin
         ins = $urandom;
         sel = $urandom_range(0, 5);
         case (sel)
            0: begin ins[27:25] = 3'b000; ins[4] = 1'b0; end
            1: begin ins[27:25] = 3'b000; ins[7] = 1'b0; ins[4] = 1'b1; end
            2: ins[27:25] = 3'b001;
            3: ins[27:25] = 3'b101;
            4: ins[31:28] = 4'hE;
            default: ins = ins;
         endcase
         run_instr(ins, 4'($urandom), $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
